// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from sync/colour inputs,
// checks line/frame timing, tracks lock, and captures the colour at a probe coordinate.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pix_en_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [11:0] rgb_i,
  input  logic [9:0]  probe_x_i,
  input  logic [8:0]  probe_y_i,
  output logic [9:0]  x_o,
  output logic [8:0]  y_o,
  output logic        active_o,
  output logic        locked_o,
  output logic        frame_start_o,
  output logic        timing_error_o,
  output logic [7:0]  error_count_o,
  output logic [11:0] probe_rgb_o,
  output logic        probe_valid_o
);

  localparam int unsigned H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_VIS_START = H_SYNC + H_BACK;
  localparam int unsigned H_VIS_END   = H_VIS_START + H_ACTIVE;
  localparam int unsigned V_VIS_START = V_SYNC + V_BACK;
  localparam int unsigned V_VIS_END   = V_VIS_START + V_ACTIVE;

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_prev_q, vs_prev_q;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        acq_bad_q, acq_bad_d;
  logic [9:0]  probe_x_q;
  logic [8:0]  probe_y_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        active_q;
  logic        frame_start_q;
  logic        timing_error_q;
  logic [7:0]  error_count_q;
  logic [11:0] probe_rgb_q;
  logic        probe_valid_q;

  logic        hs_act, vs_act;
  logic        h_edge, h_fall, v_edge, v_fall;
  logic        h_sat, h_vis, v_vis, viol, probe_hit;
  logic [10:0] h_next, v_next;
  logic [9:0]  x_d;
  logic [8:0]  y_d;

  always_comb begin
    hs_act = SYNC_ACTIVE_LOW ? ~hsync_i : hsync_i;
    vs_act = SYNC_ACTIVE_LOW ? ~vsync_i : vsync_i;
    h_edge = hs_act & ~hs_prev_q;
    h_fall = ~hs_act & hs_prev_q;
    v_edge = vs_act & ~vs_prev_q;
    v_fall = ~vs_act & vs_prev_q;
    h_next = {1'b0, h_cnt_q} + 11'd1;
    v_next = {1'b0, v_cnt_q} + 11'd1;

    // Saturation is flagged only on the step into 1023, so it reports once per missing edge.
    h_sat   = !h_edge && (h_cnt_q == 10'd1022);
    h_cnt_d = h_edge ? 10'd0 : ((h_cnt_q == 10'h3FF) ? h_cnt_q : h_next[9:0]);
    v_cnt_d = v_edge ? 10'd0 : (h_edge ? v_next[9:0] : v_cnt_q);

    viol = (state_q != StSearch) &&
           ((h_edge && (h_next != 11'(H_TOTAL))) ||
            (h_fall && (h_next != 11'(H_SYNC))) ||
            (v_edge && (v_next != 11'(V_TOTAL))) ||
            (v_fall && (v_cnt_q != 10'(V_SYNC - 1))) ||
            h_sat);

    h_vis = (32'(h_cnt_d) >= H_VIS_START) && (32'(h_cnt_d) < H_VIS_END);
    v_vis = (32'(v_cnt_d) >= V_VIS_START) && (32'(v_cnt_d) < V_VIS_END);
    x_d   = h_vis ? 10'(32'(h_cnt_d) - H_VIS_START) : x_q;
    y_d   = v_vis ? 9'(32'(v_cnt_d) - V_VIS_START) : y_q;

    state_d   = state_q;
    acq_bad_d = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (v_edge) state_d = StAcquire;
      end
      StAcquire: begin
        // A frame qualifies only if no violation occurred anywhere in it, edge sample included.
        acq_bad_d = v_edge ? 1'b0 : (acq_bad_q | viol);
        if (v_edge && !viol && !acq_bad_q) state_d = StLocked;
      end
      StLocked: begin
        if (viol) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase

    probe_hit = (state_d == StLocked) && h_vis && v_vis &&
                (x_d == probe_x_q) && (y_d == probe_y_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= StSearch;
      hs_prev_q      <= 1'b0;
      vs_prev_q      <= 1'b0;
      h_cnt_q        <= 10'd0;
      v_cnt_q        <= 10'd0;
      acq_bad_q      <= 1'b0;
      probe_x_q      <= 10'd0;
      probe_y_q      <= 9'd0;
      x_q            <= 10'd0;
      y_q            <= 9'd0;
      active_q       <= 1'b0;
      frame_start_q  <= 1'b0;
      timing_error_q <= 1'b0;
      error_count_q  <= 8'd0;
      probe_rgb_q    <= 12'd0;
      probe_valid_q  <= 1'b0;
    end else if (pix_en_i) begin
      state_q        <= state_d;
      hs_prev_q      <= hs_act;
      vs_prev_q      <= vs_act;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      acq_bad_q      <= acq_bad_d;
      x_q            <= x_d;
      y_q            <= y_d;
      active_q       <= h_vis && v_vis && (state_d == StLocked);
      frame_start_q  <= v_edge;
      timing_error_q <= viol;
      probe_valid_q  <= probe_hit;
      if (v_edge) begin
        probe_x_q <= probe_x_i;
        probe_y_q <= probe_y_i;
      end
      if (viol && (error_count_q != 8'hFF)) error_count_q <= error_count_q + 8'd1;
      if (probe_hit) probe_rgb_q <= rgb_i;
    end else begin
      frame_start_q  <= 1'b0;
      timing_error_q <= 1'b0;
      probe_valid_q  <= 1'b0;
    end
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign active_o       = active_q;
  assign locked_o       = (state_q == StLocked);
  assign frame_start_o  = frame_start_q;
  assign timing_error_o = timing_error_q;
  assign error_count_o  = error_count_q;
  assign probe_rgb_o    = probe_rgb_q;
  assign probe_valid_o  = probe_valid_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down timing (25x23 pixel frame).
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = 25, HVS = 7;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3, VT = 23, VVS = 5;
  localparam int FRAME = HT * VT;

  logic        clk, rst, pix_en, hsync, vsync;
  logic [11:0] rgb;
  logic [9:0]  probe_x;
  logic [8:0]  probe_y;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic        active_o, locked_o, frame_start_o, timing_error_o, probe_valid_o;
  logic [7:0]  error_count_o;
  logic [11:0] probe_rgb_o;

  int total = 0, bad = 0;
  int pix_idx = 0;
  int fs_cnt = 0, te_cnt = 0, pv_cnt = 0, act_cnt = 0;
  int fs_last = -1, fs_gap = 0, te_last = 0, lock_at = -1;
  int base;
  bit pulse_wide = 0;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .pix_en_i       (pix_en),
    .hsync_i        (hsync),
    .vsync_i        (vsync),
    .rgb_i          (rgb),
    .probe_x_i      (probe_x),
    .probe_y_i      (probe_y),
    .x_o            (x_o),
    .y_o            (y_o),
    .active_o       (active_o),
    .locked_o       (locked_o),
    .frame_start_o  (frame_start_o),
    .timing_error_o (timing_error_o),
    .error_count_o  (error_count_o),
    .probe_rgb_o    (probe_rgb_o),
    .probe_valid_o  (probe_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {x_o, y_o, active_o, locked_o, frame_start_o, timing_error_o,
                error_count_o, probe_rgb_o, probe_valid_o}, 64'd0);
  endtask

  // One pixel = four clocks, pix_en high for the first; outputs sampled on the next negedge.
  task automatic send_pix(input bit hs_a, input bit vs_a, input logic [11:0] c);
    @(negedge clk);
    hsync = ~hs_a; vsync = ~vs_a; rgb = c; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    pix_idx++;
    if (frame_start_o) begin
      fs_cnt++;
      if (fs_last >= 0) fs_gap = pix_idx - fs_last;
      fs_last = pix_idx;
    end
    if (timing_error_o) begin te_cnt++; te_last = pix_idx; end
    if (probe_valid_o) pv_cnt++;
    if (active_o) act_cnt++;
    if (locked_o && lock_at < 0) lock_at = pix_idx;
    @(negedge clk);
    if (frame_start_o || timing_error_o || probe_valid_o) pulse_wide = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_at(input int hc, input int vc);
    logic [11:0] c;
    int xx, yy;
    c = 12'h000;
    if (hc >= HVS && hc < HVS + HA && vc >= VVS && vc < VVS + VA) begin
      xx = hc - HVS;
      yy = vc - VVS;
      c = {xx[3:0], yy[3:0], 4'hA};
    end
    send_pix(hc < HS, vc < VS, c);
  endtask

  task automatic send_line(input int vc, input int len, input int start);
    for (int hc = start; hc < len; hc++) send_at(hc, vc);
  endtask

  task automatic send_lines(input int v0, input int v1);
    for (int vc = v0; vc <= v1; vc++) send_line(vc, HT, 0);
  endtask

  task automatic send_frame(input int short_line);
    for (int vc = 0; vc < VT; vc++) send_line(vc, (vc == short_line) ? HT - 1 : HT, 0);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 12'h0;
    probe_x = 10'd0; probe_y = 9'd0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // Clean stream: lock one frame after the first vSync edge, probe at (0,0).
    send_frame(-1);
    check("locked_after_frame1", locked_o, 1'b0);
    for (int f = 0; f < 4; f++) send_frame(-1);
    check("lock_pixel", lock_at, FRAME + 1);
    check("frame_start_count", fs_cnt, 5);
    check("frame_start_gap", fs_gap, FRAME);
    check("clean_error_count", error_count_o, 8'd0);
    check("clean_timing_err", te_cnt, 0);
    check("clean_active_pixels", act_cnt, 4 * HA * VA);
    check("probe00_valid_count", pv_cnt, 4);
    check("probe00_rgb", probe_rgb_o, 12'h00A);
    check("x_hold", x_o, 10'd15);
    check("y_hold", y_o, 9'd15);
    check("active_blank", active_o, 1'b0);

    // Probe at the last visible pixel.
    probe_x = 10'd15; probe_y = 9'd15; pv_cnt = 0;
    send_frame(-1);
    check("probe_last_rgb", probe_rgb_o, 12'hFFA);
    check("probe_last_count", pv_cnt, 1);

    // Line 10 shortened by one pixel: error at the next hSync edge.
    te_cnt = 0; act_cnt = 0; base = pix_idx;
    send_frame(10);
    check("short_err_count", te_cnt, 1);
    check("short_err_pixel", te_last, base + 11 * HT);
    check("short_error_count", error_count_o, 8'd1);
    check("short_unlocked", locked_o, 1'b0);
    check("short_active_pixels", act_cnt, 6 * HA);
    probe_x = 10'd2; probe_y = 9'd3;
    send_frame(-1);
    check("reacq_locked", locked_o, 1'b0);
    check("reacq_no_capture", pv_cnt, 1);
    check("reacq_probe_hold", probe_rgb_o, 12'hFFA);
    send_frame(-1);
    check("relock", locked_o, 1'b1);
    check("relock_probe_rgb", probe_rgb_o, 12'h23A);
    check("relock_error_count", error_count_o, 8'd1);

    // hSync missing for 1100 pixels: one saturation error only.
    te_cnt = 0;
    send_lines(0, 8);
    base = pix_idx;
    repeat (1100) send_pix(1'b0, 1'b0, 12'h000);
    check("sat_err_count", te_cnt, 1);
    check("sat_err_pixel", te_last, base + 999);
    check("sat_error_count", error_count_o, 8'd2);
    check("sat_unlocked", locked_o, 1'b0);
    send_lines(9, VT - 1);
    check("sat_single_err", te_cnt, 1);
    send_frame(-1);
    check("sat_reacq_locked", locked_o, 1'b0);
    send_lines(0, 9);
    check("sat_relock", locked_o, 1'b1);
    check("sat_y_midframe", y_o, 9'd4);

    // Asynchronous reset mid-frame.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    send_frame(-1);
    check("rst_reacq_locked", locked_o, 1'b0);
    send_frame(-1);
    check("rst_relock", locked_o, 1'b1);
    check("rst_error_count", error_count_o, 8'd0);

    // pix_en held low mid-line while pins toggle.
    te_cnt = 0;
    send_lines(0, 7);
    send_line(8, 11, 0);
    check("pre_hold_xy", {x_o, y_o, active_o, locked_o}, {10'd3, 9'd3, 1'b1, 1'b1});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hsync = 1'($urandom); vsync = 1'($urandom); rgb = 12'($urandom); pix_en = 1'b0;
    end
    check("hold_xy", {x_o, y_o, active_o, locked_o}, {10'd3, 9'd3, 1'b1, 1'b1});
    send_line(8, HT, 11);
    send_lines(9, VT - 1);
    check("post_hold_errors", {te_cnt[7:0], error_count_o}, 16'd0);
    check("post_hold_locked", locked_o, 1'b1);
    check("pulse_width", pulse_wide, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
